// File: rtl/mem_bus_resp_if.sv
// MERA-400 system bus signals between the CPU (master) and a memory responder (slave).
// Handshake: a 4-phase level protocol. The master raises exactly one of s_r/s_w
// with s_nb/s_ad/s_dt_in stable. The slave answers by raising s_ok or s_en and
// holds that answer while the request level stays high. The master then drops
// the request, and the slave drops its answer on the next edge.
interface mem_bus_resp_if;
  logic        s_r;
  logic        s_w;
  logic [3:0]  s_nb;
  logic [15:0] s_ad;
  logic [15:0] s_dt_in;
  logic [15:0] s_dt_out;
  logic        s_dt_oe;
  logic        s_ok;
  logic        s_en;
  logic        s_pe;

  modport master (
    output s_r, s_w, s_nb, s_ad, s_dt_in,
    input  s_dt_out, s_dt_oe, s_ok, s_en, s_pe
  );

  modport slave (
    input  s_r, s_w, s_nb, s_ad, s_dt_in,
    output s_dt_out, s_dt_oe, s_ok, s_en, s_pe
  );
endinterface

// File: rtl/mem_bus_resp.sv
// MERA-400 memory-module responder: NB/address decode, wait states, OK/EN answers.
// Optional per-word odd parity with a test inject hook: define MEM_BUS_RESP_PARITY_EN.
module mem_bus_resp #(
  parameter int NB_SEL     = 0,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_WORDS  = 4096,
  parameter int WAIT       = 2
) (
  input  logic                __clk,
  input  logic                clo,
  mem_bus_resp_if.slave       bus,
  output logic                busy,
  input  logic                inj_pe,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic                  bad_addr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           wdata;
  logic [15:0]           dt_out_q;
  logic                  ok_q, en_q, oe_q, pe_q;

  logic [15:0] mem [MEM_WORDS];

  logic req_any, req_one, nb_hit, in_range, do_access, do_write;
  assign req_any   = bus.s_r | bus.s_w;
  assign req_one   = bus.s_r ^ bus.s_w;
  assign nb_hit    = (bus.s_nb == 4'(NB_SEL));
  assign in_range  = (32'(bus.s_ad) < 32'(MEM_WORDS));
  assign do_access = (state == ACC) && req_any && (cnt == 4'd0);
  assign do_write  = !clo && do_access && op_wr && !bad_addr;

`ifdef MEM_BUS_RESP_PARITY_EN
  // Odd parity: stored bit makes the 17-bit word carry an odd number of ones.
  logic par [MEM_WORDS];
  always_ff @(posedge __clk) begin
    if (do_write) par[addr] <= (~^wdata) ^ inj_pe;
  end
`else
  logic unused_inj;
  assign unused_inj = inj_pe;
`endif

  // Memory is deliberately outside the clear so contents survive clo.
  always_ff @(posedge __clk) begin
    if (do_write) mem[addr] <= wdata;
  end

  always_ff @(posedge __clk) begin
    if (clo) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      bad_addr <= 1'b0;
      addr     <= '0;
      wdata    <= 16'd0;
      dt_out_q <= 16'd0;
      ok_q     <= 1'b0;
      en_q     <= 1'b0;
      oe_q     <= 1'b0;
      pe_q     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_one && nb_hit) begin
            // Out-of-range requests pass through ACC with no wait so EN
            // lands one edge after sampling, and an early drop still aborts.
            op_wr    <= bus.s_w;
            bad_addr <= !in_range;
            addr     <= bus.s_ad[ADDR_WIDTH-1:0];
            wdata    <= bus.s_dt_in;
            cnt      <= in_range ? 4'(WAIT) : 4'd0;
            state    <= ACC;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          if (!req_any) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            if (bad_addr) begin
              en_q <= 1'b1;
            end else begin
              ok_q <= 1'b1;
              if (!op_wr) begin
                dt_out_q <= mem[addr];
                oe_q     <= 1'b1;
`ifdef MEM_BUS_RESP_PARITY_EN
                pe_q     <= (par[addr] != (~^mem[addr]));
`endif
              end
            end
          end
        end
        RESP: begin
          if (!req_any) begin
            ok_q  <= 1'b0;
            en_q  <= 1'b0;
            oe_q  <= 1'b0;
            pe_q  <= 1'b0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_dt_out = dt_out_q;
  assign bus.s_dt_oe  = oe_q;
  assign bus.s_ok     = ok_q;
  assign bus.s_en     = en_q;
  assign bus.s_pe     = pe_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_bus_resp.sv
// Directed and randomized bench for mem_bus_resp with a word-array reference model.
module tb_mem_bus_resp;
  localparam int NB_SEL     = 0;
  localparam int ADDR_WIDTH = 12;
  localparam int MEM_WORDS  = 4096;
  localparam int WAIT       = 2;

  logic       clk;
  logic       clo;
  logic       busy;
  logic       inj_pe;
  logic [1:0] dbg_state;

  mem_bus_resp_if bus();

  mem_bus_resp #(
    .NB_SEL(NB_SEL), .ADDR_WIDTH(ADDR_WIDTH), .MEM_WORDS(MEM_WORDS), .WAIT(WAIT)
  ) dut (
    .__clk(clk), .clo(clo), .bus(bus), .busy(busy), .inj_pe(inj_pe), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int          checks;
  int          failures;
  logic [15:0] exp_q[$];
  logic [15:0] ref_mem [int];
  logic        ref_par [int];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {ok, en, oe, pe, busy}
  function automatic logic [31:0] rv();
    return {27'd0, bus.s_ok, bus.s_en, bus.s_dt_oe, bus.s_pe, busy};
  endfunction

  task automatic drive_idle();
    bus.s_r = 1'b0; bus.s_w = 1'b0; bus.s_nb = 4'd0;
    bus.s_ad = 16'd0; bus.s_dt_in = 16'd0; inj_pe = 1'b0;
  endtask

  // Full transfer at the current negedge; model decides latency and answer.
  task automatic xfer(input bit wr, input logic [15:0] ad, input logic [15:0] dt, input bit inj);
    bit          in_rng;
    int          lat;
    logic        exp_pe;
    logic [15:0] exp_d;
    logic [31:0] exp_v;
    in_rng = (int'(ad) < MEM_WORDS);
    lat    = in_rng ? WAIT + 1 : 1;
    exp_pe = 1'b0;
    exp_d  = 16'd0;
    if (!wr && in_rng) begin
      exp_q.push_back(ref_mem[int'(ad)]);
`ifdef MEM_BUS_RESP_PARITY_EN
      exp_pe = ref_par[int'(ad)];
`endif
    end
    bus.s_r = !wr; bus.s_w = wr; bus.s_nb = 4'(NB_SEL);
    bus.s_ad = ad; bus.s_dt_in = dt; inj_pe = inj;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait", rv(), 32'b00001);
    end
    @(negedge clk);
    exp_v = {27'd0, in_rng, !in_rng, (!wr && in_rng), exp_pe, 1'b1};
    chk(wr ? "wr_resp" : "rd_resp", rv(), exp_v);
    if (!wr && in_rng) begin
      exp_d = exp_q.pop_front();
      chk("rd_data", {16'd0, bus.s_dt_out}, {16'd0, exp_d});
    end
    if (wr && in_rng) begin
      ref_mem[int'(ad)] = dt;
      ref_par[int'(ad)] = inj;
    end
    // bus inputs change while the answer is held; they must be ignored
    bus.s_ad = 16'($urandom); bus.s_dt_in = 16'($urandom);
    @(negedge clk);
    chk("hold", rv(), exp_v);
    if (!wr && in_rng) chk("hold_data", {16'd0, bus.s_dt_out}, {16'd0, exp_d});
    bus.s_r = 1'b0; bus.s_w = 1'b0; inj_pe = 1'b0;
    @(negedge clk);
    chk("release", rv(), 32'd0);
  endtask

  initial begin
    logic [15:0] pool [8];
    checks = 0;
    failures = 0;
    drive_idle();
    clo = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_resp", rv(), 32'd0);
    chk("reset_dout", {16'd0, bus.s_dt_out}, 32'd0);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    clo = 1'b0;
    @(negedge clk);

    // basic write then read
    xfer(1'b1, 16'h0123, 16'hBEEF, 1'b0);
    xfer(1'b0, 16'h0123, 16'h0000, 1'b0);

    // out of range -> EN
    xfer(1'b0, 16'h1000, 16'h0000, 1'b0);
    xfer(1'b1, 16'hFFFF, 16'h1234, 1'b0);

    // NB mismatch: no answer for 20 cycles
    bus.s_r = 1'b1; bus.s_nb = 4'd3; bus.s_ad = 16'h0123;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("nb_miss", rv(), 32'd0);
    end
    drive_idle();
    @(negedge clk);

    // write aborted during ACC after edge 1
    xfer(1'b1, 16'h0010, 16'h5A5A, 1'b0);
    bus.s_w = 1'b1; bus.s_nb = 4'(NB_SEL); bus.s_ad = 16'h0010; bus.s_dt_in = 16'h1111;
    @(negedge clk);
    chk("abort_e0", rv(), 32'b00001);
    @(negedge clk);
    chk("abort_e1", rv(), 32'b00001);
    bus.s_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_idle", rv(), 32'd0);
    end
    xfer(1'b0, 16'h0010, 16'h0000, 1'b0);

    // clo while responding to a read
    bus.s_r = 1'b1; bus.s_nb = 4'(NB_SEL); bus.s_ad = 16'h0123;
    repeat (WAIT + 2) @(negedge clk);
    chk("clo_pre", rv(), 32'b10101);
    clo = 1'b1;
    @(negedge clk);
    chk("clo_resp", rv(), 32'd0);
    chk("clo_dout", {16'd0, bus.s_dt_out}, 32'd0);
    clo = 1'b0; bus.s_r = 1'b0;
    @(negedge clk);
    chk("clo_after", rv(), 32'd0);
    xfer(1'b0, 16'h0123, 16'h0000, 1'b0);

    // protocol violation: both levels high
    bus.s_r = 1'b1; bus.s_w = 1'b1; bus.s_nb = 4'(NB_SEL); bus.s_ad = 16'h0123;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("both_rw", rv(), 32'd0);
    end
    drive_idle();
    @(negedge clk);

    // parity inject and rewrite (s_pe stays 0 when parity is not built)
    xfer(1'b1, 16'h0200, 16'h00FF, 1'b1);
    xfer(1'b0, 16'h0200, 16'h0000, 1'b0);
    xfer(1'b1, 16'h0200, 16'h00FF, 1'b0);
    xfer(1'b0, 16'h0200, 16'h0000, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 8; i++) begin
      pool[i] = 16'($urandom_range(0, MEM_WORDS - 1));
      xfer(1'b1, pool[i], 16'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0, 3:    xfer(1'b0, pool[$urandom_range(0, 7)], 16'd0, 1'b0);
        1:       xfer(1'b1, pool[$urandom_range(0, 7)], 16'($urandom), 1'($urandom_range(0, 1)));
        default: xfer(1'($urandom_range(0, 1)), 16'($urandom_range(MEM_WORDS, 65535)),
                      16'($urandom), 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
